cra_sbr_stack: RTL and testbench

//  CRAM CALL/RETURN subroutine stack controller for the M8541 CRA address path.

---
 rtl/kl10_cra_pkg.sv | 6 +
 rtl/cra_sbr_ram.sv | 19 +
 rtl/cra_sbr_stack.sv | 125 ++++++++++++
 tb/tb_cra_sbr_stack.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/kl10_cra_pkg.sv
// kl10_cra_pkg: shared CRA address types, subroutine-stack op codes and default stack depth.
package kl10_cra_pkg;
    typedef logic [0:10] cramAdr_t;
    typedef enum logic [2:0] {SBR_HOLD, SBR_PUSH, SBR_POP, SBR_LOAD, SBR_DIAG} sbrOp_t;
    localparam int SBR_DEPTH = 16;
endpackage

// File: rtl/cra_sbr_ram.sv
// cra_sbr_ram: DEPTH x W subroutine-stack register file, one synchronous write port, one combinational read port.
module cra_sbr_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 11
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [0:$clog2(DEPTH)-1]   wa,
    input  logic [0:W-1]               wd,
    input  logic [0:$clog2(DEPTH)-1]   ra,
    output logic [0:W-1]               rd
);
    logic [0:W-1] mem_q [DEPTH];

    always_ff @(posedge clk)
        if (we) mem_q[wa] <= wd;

    assign rd = mem_q[ra];
endmodule

// File: rtl/cra_sbr_stack.sv
// cra_sbr_stack: CRAM CALL/RETURN subroutine stack; SBR_STACK_PARITY_EN adds per-entry odd parity and a sticky parityErr.
module cra_sbr_stack
    import kl10_cra_pkg::*;
#(
    parameter int DEPTH = SBR_DEPTH,
    parameter int AW    = 11
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       force1777,
    input  logic [0:AW-1]              pushAdr,
    input  logic                       diagWrite,
    input  logic [0:AW-1]              diagData,
    output logic [0:AW-1]              sbrRet,
    output logic [0:$clog2(DEPTH)-1]   stackAdr,
    output logic [0:$clog2(DEPTH)]     depth,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       parityErr
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [0:PW] FULL_DEPTH = (PW+1)'(DEPTH);
    localparam logic [0:PW] ONE_DEPTH  = (PW+1)'(1);
`ifdef SBR_STACK_PARITY_EN
    localparam int W = AW + 1;
`else
    localparam int W = AW;
`endif

    sbrOp_t         op;
    logic [0:PW-1]  ptr_q, ptr_d;
    logic [0:PW]    depth_q, depth_d;
    logic [0:AW-1]  sbr_ret_q, sbr_ret_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;
    logic           we;
    logic [0:PW-1]  wa;
    logic [0:AW-1]  wdat;
    logic [0:W-1]   wd, rd;

    always_comb
        op = diagWrite ? SBR_DIAG :
             force1777 ? SBR_PUSH :
             (call && ret) ? SBR_LOAD :
             call ? SBR_PUSH :
             ret ? SBR_POP : SBR_HOLD;

    always_comb begin
        ptr_d       = ptr_q;
        depth_d     = depth_q;
        sbr_ret_d   = sbr_ret_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        we          = 1'b0;
        wa          = ptr_q;
        wdat        = pushAdr;
        if (op == SBR_DIAG) begin
            we        = 1'b1;
            wdat      = diagData;
            sbr_ret_d = diagData;
        end else if (op == SBR_LOAD) begin
            we        = 1'b1;
            sbr_ret_d = pushAdr;
            depth_d   = (depth_q == '0) ? ONE_DEPTH : depth_q;
        end else if (op == SBR_PUSH) begin
            we          = 1'b1;
            wa          = ptr_q + 1'b1;
            ptr_d       = ptr_q + 1'b1;
            sbr_ret_d   = pushAdr;
            depth_d     = (depth_q == FULL_DEPTH) ? FULL_DEPTH : depth_q + 1'b1;
            overflow_d  = overflow_q | (depth_q == FULL_DEPTH);
        end else if (op == SBR_POP) begin
            ptr_d       = ptr_q - 1'b1;
            depth_d     = (depth_q == '0) ? depth_q : depth_q - 1'b1;
            underflow_d = underflow_q | (depth_q == '0);
            // Only a still-valid entry becomes the new top; otherwise expose zero.
            sbr_ret_d   = (depth_q > ONE_DEPTH) ? rd[0:AW-1] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            depth_q     <= '0;
            sbr_ret_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            depth_q     <= depth_d;
            sbr_ret_q   <= sbr_ret_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef SBR_STACK_PARITY_EN
    logic parity_err_q, parity_err_d;
    assign wd           = {wdat, ~^wdat};
    assign parity_err_d = parity_err_q | (op == SBR_POP && depth_q > ONE_DEPTH && !(^rd));
    always_ff @(posedge clk)
        parity_err_q <= reset ? 1'b0 : parity_err_d;
    assign parityErr = parity_err_q;
`else
    assign wd        = wdat;
    assign parityErr = 1'b0;
`endif

    cra_sbr_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
        .clk (clk),
        .we  (we),
        .wa  (wa),
        .wd  (wd),
        .ra  (ptr_q - 1'b1),
        .rd  (rd)
    );

    assign sbrRet    = sbr_ret_q;
    assign stackAdr  = ptr_q;
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_cra_sbr_stack.sv
// tb_cra_sbr_stack: directed self-checking bench for cra_sbr_stack (parity case only with SBR_STACK_PARITY_EN).
module tb_cra_sbr_stack;
    logic        clk = 1'b0;
    logic        reset, call, ret, force1777, diagWrite;
    logic [0:10] pushAdr, diagData, sbrRet;
    logic [0:3]  stackAdr;
    logic [0:4]  depth;
    logic        overflow, underflow, parityErr;
    int          total = 0;
    int          bad = 0;

    cra_sbr_stack dut (
        .clk(clk), .reset(reset), .call(call), .ret(ret), .force1777(force1777),
        .pushAdr(pushAdr), .diagWrite(diagWrite), .diagData(diagData),
        .sbrRet(sbrRet), .stackAdr(stackAdr), .depth(depth),
        .overflow(overflow), .underflow(underflow), .parityErr(parityErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic rt, input logic f,
                        input logic dw, input logic [0:10] a, input logic [0:10] dd);
        reset = r; call = c; ret = rt; force1777 = f; diagWrite = dw; pushAdr = a; diagData = dd;
        @(posedge clk);
        #1;
        reset = 0; call = 0; ret = 0; force1777 = 0; diagWrite = 0;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [0:10] a);
        step(0, 1, 0, 0, 0, a, 0);
    endtask

    task automatic pop();
        step(0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; call = 0; ret = 0; force1777 = 0; diagWrite = 0; pushAdr = 0; diagData = 0;
        do_reset();
        do_reset();
        check("rst_sbrRet", sbrRet, 0);
        check("rst_depth", depth, 0);
        check("rst_stackAdr", stackAdr, 0);
        check("rst_flags", {overflow, underflow, parityErr}, 0);

        push('o123);
        check("t1_sbrRet", sbrRet, 'o123);
        check("t1_depth", depth, 1);
        check("t1_stackAdr", stackAdr, 1);

        do_reset();
        push('o100); push('o200); push('o300);
        check("t2_top", sbrRet, 'o300);
        check("t2_depth3", depth, 3);
        pop();
        check("t2_pop1", sbrRet, 'o200);
        pop();
        check("t2_pop2", sbrRet, 'o100);
        pop();
        check("t2_pop3", sbrRet, 0);
        check("t2_depth0", depth, 0);
        check("t2_flags", {overflow, underflow}, 0);

        do_reset();
        for (int i = 1; i <= 17; i++) push(11'(i));
        check("t3_depth", depth, 16);
        check("t3_overflow", overflow, 1);
        check("t3_stackAdr", stackAdr, 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_ret%0d", i), sbrRet, 17 - i);
            pop();
        end
        check("t3_sbrRet_empty", sbrRet, 0);
        check("t3_depth0", depth, 0);
        check("t3_no_underflow", underflow, 0);

        pop();
        check("t4_underflow", underflow, 1);
        check("t4_sbrRet", sbrRet, 0);
        check("t4_stackAdr", stackAdr, 0);
        check("t4_depth", depth, 0);
        push('o555);
        check("t4_push_sbrRet", sbrRet, 'o555);
        check("t4_push_depth", depth, 1);
        check("t4_sticky", {overflow, underflow}, 2'b11);
        do_reset();
        check("t4_flags_clear", {overflow, underflow}, 0);

        push('o100); push('o200);
        step(0, 0, 1, 1, 0, 'o1234, 0);
        check("t5_force_depth", depth, 3);
        check("t5_force_sbrRet", sbrRet, 'o1234);
        check("t5_force_stackAdr", stackAdr, 3);
        step(0, 1, 1, 0, 0, 'o777, 0);
        check("t5_load_depth", depth, 3);
        check("t5_load_sbrRet", sbrRet, 'o777);
        check("t5_load_stackAdr", stackAdr, 3);
        pop();
        check("t5_pop_sbrRet", sbrRet, 'o200);
        step(0, 1, 1, 1, 1, 'o1111, 'o456);
        check("t5_diag_sbrRet", sbrRet, 'o456);
        check("t5_diag_depth", depth, 2);
        check("t5_diag_stackAdr", stackAdr, 2);
        push('o333);
        pop();
        check("t5_diag_stored", sbrRet, 'o456);
        pop();
        check("t5_pop_after_diag", sbrRet, 'o100);
        check("t5_depth1", depth, 1);

        do_reset();
        step(0, 1, 1, 0, 0, 'o321, 0);
        check("t7_load_empty_depth", depth, 1);
        check("t7_load_empty_sbrRet", sbrRet, 'o321);
        check("t7_load_empty_stackAdr", stackAdr, 0);
        step(1, 1, 0, 0, 0, 'o654, 0);
        check("t7_rst_push_depth", depth, 0);
        check("t7_rst_push_sbrRet", sbrRet, 0);
        check("t7_rst_push_stackAdr", stackAdr, 0);

`ifdef SBR_STACK_PARITY_EN
        do_reset();
        push('o100); push('o200);
        check("t6_no_perr", parityErr, 0);
        dut.u_ram.mem_q[1][11] = ~dut.u_ram.mem_q[1][11];
        pop();
        check("t6_perr", parityErr, 1);
`else
        check("t6_perr_tied", parityErr, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
